// File: rtl/fxp_pkg.sv
// Shared fixed-point divider definitions: Q6.10 format constants and FSM state type.
package fxp_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 10;

    localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/fxp_sat.sv
// Combinational sign application and saturation of an unsigned quotient magnitude
// to a WIDTH-bit two's complement result; flags when the clamp was needed.
module fxp_sat #(
    parameter int WIDTH = fxp_pkg::WIDTH,
    parameter int MW    = fxp_pkg::WIDTH + fxp_pkg::FRAC + 1
) (
    input  logic [MW-1:0]    mag,
    input  logic             neg,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);

    localparam logic [MW-1:0]    POS_LIM = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [MW-1:0]    NEG_LIM = POS_LIM + MW'(1);
    localparam logic [WIDTH-1:0] SAT_HI  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] low;

    always_comb begin
        low = mag[WIDTH-1:0];
        q   = '0;
        ovf = 1'b0;
        // A zero magnitude is never treated as negative, so -0 cannot appear.
        if (neg && (mag != '0)) begin
            if (mag > NEG_LIM) begin
                q   = SAT_LO;
                ovf = 1'b1;
            end else begin
                q = -low;
            end
        end else if (mag > POS_LIM) begin
            q   = SAT_HI;
            ovf = 1'b1;
        end else begin
            q = low;
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed Q6.10 divider: restoring division, one quotient bit per cycle.
// Define FXP_DIV_ROUND_EN for round-to-nearest (ties away from zero); default truncates.
module fxp_div_seq #(
    parameter int WIDTH = fxp_pkg::WIDTH,
    parameter int FRAC  = fxp_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             div_zero,
    output logic             ovf
);

    import fxp_pkg::*;

    localparam int DW = WIDTH + FRAC;
    localparam int MW = DW + 1;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0]    LAST   = CW'(DW - 1);
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [DW-1:0]    quo;     // dividend bits shift out the top, quotient bits shift in below
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvs;
    logic             neg_r, a_neg, b_zero;
    logic [WIDTH-1:0] q_r;
    logic             dz_r, ovf_r;

    logic             accept, last;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH+1:0] rem_sh, trial;
    logic             qbit;
    logic [WIDTH:0]   rem_nxt;
    logic [DW-1:0]    quo_nxt;
    logic [MW-1:0]    mag;
    logic [WIDTH-1:0] sat_q;
    logic             sat_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Unsigned negation keeps the most negative operand exact (0x8000 -> 32768).
    always_comb begin
        abs_a   = A[WIDTH-1] ? -A : A;
        abs_b   = B[WIDTH-1] ? -B : B;
        rem_sh  = {rem, quo[DW-1]};
        trial   = rem_sh - {2'b00, dvs};
        qbit    = ~trial[WIDTH+1];
        rem_nxt = qbit ? trial[WIDTH:0] : rem_sh[WIDTH:0];
        quo_nxt = {quo[DW-2:0], qbit};
`ifdef FXP_DIV_ROUND_EN
        mag = {1'b0, quo_nxt} + MW'({rem_nxt, 1'b0} >= {2'b00, dvs});
`else
        mag = {1'b0, quo_nxt};
`endif
    end

    fxp_sat #(
        .WIDTH (WIDTH),
        .MW    (MW)
    ) u_sat (
        .mag (mag),
        .neg (neg_r),
        .q   (sat_q),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            neg_r  <= 1'b0;
            a_neg  <= 1'b0;
            b_zero <= 1'b0;
            q_r    <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            quo    <= {abs_a, {FRAC{1'b0}}};
            rem    <= '0;
            dvs    <= abs_b;
            neg_r  <= A[WIDTH-1] ^ B[WIDTH-1];
            a_neg  <= A[WIDTH-1];
            b_zero <= (B == '0);
        end else if (state == CALC) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (last) begin
                // B=0 still runs the full iteration count; its result is overridden here.
                cnt   <= '0;
                q_r   <= b_zero ? (a_neg ? SAT_LO : SAT_HI) : sat_q;
                dz_r  <= b_zero;
                ovf_r <= ~b_zero & sat_ovf;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign Q        = q_r;
    assign div_zero = dz_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Scoreboard bench for fxp_div_seq; expected results follow FXP_DIV_ROUND_EN when defined.
module tb_fxp_div_seq;

    typedef struct packed {
        logic [15:0] q;
        logic        dz;
        logic        ov;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        dz;
        logic        ov;
    } vec_t;

`ifdef FXP_DIV_ROUND_EN
    localparam logic [15:0] Q_SMALL_POS = 16'h0001;
    localparam logic [15:0] Q_SMALL_NEG = 16'hFFFF;
`else
    localparam logic [15:0] Q_SMALL_POS = 16'h0000;
    localparam logic [15:0] Q_SMALL_NEG = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
    logic [15:0] A, B, Q;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t dir_tbl[12];

    fxp_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t    e;
        longint  sa, sbv, ma, mb, num, mag, r;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.q  = 16'h0000;
        if (sbv == 0) begin
            e.dz = 1'b1;
            e.q  = (sa < 0) ? 16'h8000 : 16'h7FFF;
            return e;
        end
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sbv < 0) ? -sbv : sbv;
        num = ma * 1024;
        mag = num / mb;
        r   = num % mb;
`ifdef FXP_DIV_ROUND_EN
        if (2 * r >= mb) mag = mag + 1;
`endif
        if (((sa < 0) != (sbv < 0)) && mag != 0) begin
            if (mag > 32768) begin e.q = 16'h8000; e.ov = 1'b1; end
            else e.q = 16'(-mag);
        end else if (mag > 32767) begin
            e.q = 16'h7FFF; e.ov = 1'b1;
        end else begin
            e.q = 16'(mag);
        end
        return e;
    endfunction

    // Drives one operation, pushes its expectation, waits (bounded) for the result.
    // lat counts edges from the accepting edge to the first edge that sees out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                          input bit consume, output int lat,
                          output logic [15:0] q, output logic dz, output logic ov);
        int w;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        sb.push_back(e);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        q = Q; dz = div_zero; ov = ovf;
        if (consume && lat > 0) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset.in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got=%b exp=0", out_valid); end
        checks++; if (Q !== 16'h0000)     begin errors++; $display("FAIL reset.Q got=%h exp=0000", Q); end
        checks++; if (div_zero !== 1'b0)  begin errors++; $display("FAIL reset.div_zero got=%b exp=0", div_zero); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset.ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_directed();
        int lat; logic [15:0] q; logic dz, ov; exp_t e;
        dir_tbl = '{
            '{16'h0400, 16'h0200, 16'h0800, 1'b0, 1'b0},
            '{16'hF400, 16'h0800, 16'hFA00, 1'b0, 1'b0},
            '{16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0},
            '{16'h0400, 16'h0000, 16'h7FFF, 1'b1, 1'b0},
            '{16'hFC00, 16'h0000, 16'h8000, 1'b1, 1'b0},
            '{16'h7C00, 16'h0001, 16'h7FFF, 1'b0, 1'b1},
            '{16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0},
            '{16'h0002, 16'h0C00, Q_SMALL_POS, 1'b0, 1'b0},
            '{16'hFFFE, 16'h0C00, Q_SMALL_NEG, 1'b0, 1'b0},
            '{16'h8000, 16'hFC00, 16'h7FFF, 1'b0, 1'b1},
            '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1},
            '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            run_op(dir_tbl[i].a, dir_tbl[i].b, '{dir_tbl[i].q, dir_tbl[i].dz, dir_tbl[i].ov}, 1'b1, lat, q, dz, ov);
            e = sb.pop_front();
            checks++; if (lat != 27) begin errors++; $display("FAIL dir%0d.latency got=%0d exp=27", i, lat); end
            checks++; if (q !== e.q)  begin errors++; $display("FAIL dir%0d.Q got=%h exp=%h", i, q, e.q); end
            checks++; if (dz !== e.dz) begin errors++; $display("FAIL dir%0d.div_zero got=%b exp=%b", i, dz, e.dz); end
            checks++; if (ov !== e.ov) begin errors++; $display("FAIL dir%0d.ovf got=%b exp=%b", i, ov, e.ov); end
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] q, a, b; logic dz, ov; exp_t e;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 8)) - 16'd4;
                1:       b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            run_op(a, b, model(a, b), 1'b1, lat, q, dz, ov);
            e = sb.pop_front();
            checks++; if (lat != 27) begin errors++; $display("FAIL rnd%0d.latency got=%0d exp=27", i, lat); end
            checks++; if ({q, dz, ov} !== {e.q, e.dz, e.ov}) begin
                errors++;
                $display("FAIL rnd%0d A=%h B=%h got Q=%h dz=%b ovf=%b exp Q=%h dz=%b ovf=%b",
                         i, a, b, q, dz, ov, e.q, e.dz, e.ov);
            end
        end
    endtask

    task automatic test_hold();
        int lat; logic [15:0] q; logic dz, ov; exp_t e;
        run_op(16'h0400, 16'h0C00, '{16'h0155, 1'b0, 1'b0}, 1'b0, lat, q, dz, ov);
        e = sb.pop_front();
        checks++; if (q !== e.q) begin errors++; $display("FAIL hold.first_Q got=%h exp=%h", q, e.q); end
        A = 16'h7C00; B = 16'h0001; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d.out_valid got=%b exp=1", c, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold%0d.in_ready got=%b exp=0", c, in_ready); end
            checks++; if ({Q, div_zero, ovf} !== {e.q, e.dz, e.ov}) begin
                errors++; $display("FAIL hold%0d.result got=%h/%b/%b exp=%h/%b/%b", c, Q, div_zero, ovf, e.q, e.dz, e.ov);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] q; logic dz, ov; exp_t e;
        run_op(16'hF400, 16'h0800, '{16'hFA00, 1'b0, 1'b0}, 1'b0, lat, q, dz, ov);
        e = sb.pop_front();
        checks++; if (q !== e.q) begin errors++; $display("FAIL b2b.first_Q got=%h exp=%h", q, e.q); end
        A = 16'h0400; B = 16'h0200; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b.no_accept_on_dequeue got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        sb.push_back(model(16'h0400, 16'h0200));
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        e = sb.pop_front();
        checks++; if (lat != 27) begin errors++; $display("FAIL b2b.latency got=%0d exp=27", lat); end
        checks++; if (Q !== 16'h0800 || e.q !== 16'h0800) begin errors++; $display("FAIL b2b.second_Q got=%h exp=0800", Q); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, seen; logic [15:0] q; logic dz, ov; exp_t e;
        run_op(16'h7C00, 16'h0001, '{16'h7FFF, 1'b0, 1'b1}, 1'b1, lat, q, dz, ov);
        e = sb.pop_front();
        checks++; if ({q, ov} !== {e.q, e.ov}) begin errors++; $display("FAIL rstmid.pre got=%h/%b exp=%h/%b", q, ov, e.q, e.ov); end
        @(negedge clk);
        A = 16'h0400; B = 16'h0200; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid.state got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        checks++; if ({Q, div_zero, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid.outputs got=%h/%b/%b exp=0000/0/0", Q, div_zero, ovf);
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid.out_valid_after got=%0d cycles exp=0", seen); end

        run_op(16'h0400, 16'h0000, '{16'h7FFF, 1'b1, 1'b0}, 1'b0, lat, q, dz, ov);
        e = sb.pop_front();
        checks++; if ({q, dz} !== {e.q, e.dz}) begin errors++; $display("FAIL rstdone.pre got=%h/%b exp=%h/%b", q, dz, e.q, e.dz); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid, Q, div_zero, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstdone.outputs got rdy=%b vld=%b Q=%h dz=%b ovf=%b exp 1/0/0000/0/0",
                               in_ready, out_valid, Q, div_zero, ovf);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard.leftover got=%0d exp=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog.timeout got=expired exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fxp_div_seq.md
FXP_DIV_SEQ -- requirements
Module: fxp_div_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits, signed two's complement.
REQ-002 Parameter FRAC, default 10: fractional bits (Q6.10 format, same as the team's fixed-point multiplier).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands A and B valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  signed dividend, Q6.10.
REQ-008 B  input  WIDTH  signed divisor, Q6.10.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 Q  output  WIDTH  signed quotient A/B, Q6.10, saturated.
REQ-012 div_zero  output  1  B was zero for the current result.
REQ-013 ovf  output  1  true quotient was outside the representable range; Q was saturated.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 In IDLE, in_ready=1 and out_valid=0; all other states: in_ready=0.
REQ-016 Accept occurs on an edge where in_valid&in_ready; operands are registered, and the FSM moves IDLE->CALC.
REQ-017 Arithmetic: dividend magnitude = |A|<<FRAC (26 bits); divisor magnitude = |B|; restoring division, one quotient bit per cycle, MSB first.
REQ-018 CALC SHALL last exactly WIDTH+FRAC (26) cycles, including for B=0, so latency is fixed; CALC->DONE after the last iteration.
REQ-019 out_valid SHALL first be high 27 rising edges after the accepting edge.
REQ-020 Sign: the result is negative iff sign(A)!=sign(B) and the magnitude is nonzero; magnitude rounds toward zero (see REQ-031).
REQ-021 Saturation: positive magnitude >32767 -> Q=0x7FFF; negative magnitude >32768 -> Q=0x8000; ovf=1 in either case, else ovf=0.
REQ-022 B=0: Q=0x7FFF if A>=0, 0x8000 if A<0; div_zero=1, ovf=0.
REQ-023 In DONE, Q/div_zero/ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 DONE->IDLE on an edge with out_ready=1; new operands SHALL NOT be accepted on that same edge.
REQ-025 A=0x8000 (magnitude 32768) SHALL be handled exactly, with no wrap.

Reset
REQ-026 On rst=1 at any edge, including mid-CALC or in DONE: state=IDLE, out_valid=0, Q=0, div_zero=0, ovf=0, iteration counter=0.
REQ-027 in_ready SHALL be 1 in the cycle following the reset edge; any in-flight result is discarded.

Configuration
REQ-028 Macro FXP_DIV_ROUND_EN selects round-to-nearest.
REQ-029 With FXP_DIV_ROUND_EN defined: after the final iteration, if 2*remainder >= |B|, the magnitude increments by 1 before sign and saturation are applied; ties round away from zero.
REQ-030 With FXP_DIV_ROUND_EN defined: saturation (REQ-021) is applied after rounding.
REQ-031 Without FXP_DIV_ROUND_EN: truncate toward zero; no extra logic and no latency change.

Structure
REQ-032 Shared package fxp_pkg SHALL hold WIDTH, FRAC, Q_MAX (0x7FFF), Q_MIN (0x8000), and the FSM state enum type.
REQ-033 One sub-module, fxp_sat: combinational sign-apply plus saturation of a 27-bit magnitude to WIDTH bits, with an ovf output.
REQ-034 The iteration counter, remainder, and quotient shift registers SHALL reside in fxp_div_seq.

Verification
REQ-035 A=0x0400, B=0x0200 -> Q=0x0800 (2.0), ovf=0, div_zero=0; out_valid high at edge 27 after accept.
REQ-036 A=0xF400 (-3.0), B=0x0800 (2.0) -> Q=0xFA00 (-1.5); A=0x0400, B=0x0C00 -> Q=0x0155 in both configurations.
REQ-037 A=0x0400, B=0x0000 -> Q=0x7FFF, div_zero=1; A=0xFC00, B=0x0000 -> Q=0x8000, div_zero=1.
REQ-038 A=0x7C00, B=0x0001 -> Q=0x7FFF, ovf=1; A=0x8000, B=0x0400 -> Q=0x8000, ovf=0.
REQ-039 A=0x0002, B=0x0C00 -> Q=0x0001 with FXP_DIV_ROUND_EN defined, 0x0000 without.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> Q is stable and in_ready=0 throughout; assert rst at CALC cycle 10 -> IDLE next cycle, out_valid never asserted.
